lane_serializer: RTL and testbench



---
 rtl/lane_serializer_pkg.sv | 22 ++
 rtl/lane_serializer_buf.sv | 36 +++
 rtl/lane_serializer.sv | 158 +++++++++++++++
 tb/tb_lane_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_serializer_pkg.sv
// Shared types and length helpers for the multi-lane frame serializer.
package lane_serializer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    // A length of 0, or one above the maximum, means a full frame.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned n_samples);
        if (len == 0 || len > n_samples) begin
            return n_samples;
        end
        return len;
    endfunction

    function automatic int unsigned beats(input int unsigned len, input int unsigned n_samples,
                                          input int unsigned n_lanes);
        return (eff_len(len, n_samples) + n_lanes - 1) / n_lanes;
    endfunction

endpackage

// File: rtl/lane_serializer_buf.sv
// Frame register bank plus effective-length register with load enable and synchronous reset.
module lane_serializer_buf #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned LEN_W     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] load_msg [N_SAMPLES],
    input  logic [LEN_W-1:0]     load_len,
    output logic [BIT_WIDTH-1:0] msg      [N_SAMPLES],
    output logic [LEN_W-1:0]     len
);

    logic [BIT_WIDTH-1:0] msg_q [N_SAMPLES];
    logic [LEN_W-1:0]     len_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(N_SAMPLES); i++) begin
                msg_q[i] <= '0;
            end
            len_q <= '0;
        end else if (load) begin
            for (int i = 0; i < int'(N_SAMPLES); i++) begin
                msg_q[i] <= load_msg[i];
            end
            len_q <= load_len;
        end
    end

    assign msg = msg_q;
    assign len = len_q;

endmodule

// File: rtl/lane_serializer.sv
// Frame-to-lanes serializer: one frame in, N_LANES words per beat out with mask and last flag.
// Define LANE_SERIALIZER_PINGPONG_EN to add a shadow buffer for zero-bubble back-to-back frames.
module lane_serializer
    import lane_serializer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned N_LANES   = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [BIT_WIDTH-1:0]               recv_msg [N_SAMPLES],
    input  logic [$clog2(N_SAMPLES+1)-1:0]     recv_len,
    input  logic                               recv_val,
    output logic                               recv_rdy,
    output logic [BIT_WIDTH-1:0]               send_msg [N_LANES],
    output logic [N_LANES-1:0]                 send_mask,
    output logic                               send_last,
    output logic                               send_val,
    input  logic                               send_rdy
);

    localparam int unsigned LEN_W = $clog2(N_SAMPLES + 1);
    localparam int unsigned KW    = $clog2(N_SAMPLES / N_LANES) + 1;
    localparam int unsigned IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [BIT_WIDTH-1:0] act_msg      [N_SAMPLES];
    logic [BIT_WIDTH-1:0] act_load_msg [N_SAMPLES];
    logic [LEN_W-1:0]     act_len, act_load_len, recv_eff_len;
    logic                 act_load, recv_fire, send_fire, last_beat;

    assign recv_eff_len = LEN_W'(eff_len(32'(recv_len), N_SAMPLES));
    assign send_val     = (state_q == StSend);
    assign recv_fire    = recv_val && recv_rdy;
    assign send_fire    = send_val && send_rdy;
    assign last_beat    = (32'(k_q) == beats(32'(act_len), N_SAMPLES, N_LANES) - 1);
    assign send_last    = send_val && last_beat;

    lane_serializer_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .LEN_W     (LEN_W)
    ) u_active (
        .clk      (clk),
        .reset    (reset),
        .load     (act_load),
        .load_msg (act_load_msg),
        .load_len (act_load_len),
        .msg      (act_msg),
        .len      (act_len)
    );

`ifdef LANE_SERIALIZER_PINGPONG_EN
    logic [BIT_WIDTH-1:0] sh_msg [N_SAMPLES];
    logic [LEN_W-1:0]     sh_len;
    logic                 sh_load, sh_full_q, sh_full_d, promote;

    lane_serializer_buf #(
        .BIT_WIDTH (BIT_WIDTH),
        .N_SAMPLES (N_SAMPLES),
        .LEN_W     (LEN_W)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .load_msg (recv_msg),
        .load_len (recv_eff_len),
        .msg      (sh_msg),
        .len      (sh_len)
    );

    assign recv_rdy = !sh_full_q;
    assign promote  = send_fire && last_beat && sh_full_q;
    // A frame arriving with the last beat and an empty shadow skips the shadow.
    assign sh_load  = recv_fire && (state_q == StSend) && !(send_fire && last_beat);
    assign act_load = promote ||
                      (recv_fire && ((state_q == StIdle) || (send_fire && last_beat)));
    assign act_load_len = promote ? sh_len : recv_eff_len;

    always_comb begin
        for (int i = 0; i < int'(N_SAMPLES); i++) begin
            act_load_msg[i] = promote ? sh_msg[i] : recv_msg[i];
        end
    end

    always_comb begin
        sh_full_d = sh_full_q;
        if (promote) begin
            sh_full_d = 1'b0;
        end
        if (sh_load) begin
            sh_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_full_q <= 1'b0;
        end else begin
            sh_full_q <= sh_full_d;
        end
    end
`else
    assign recv_rdy     = (state_q == StIdle);
    assign act_load     = recv_fire;
    assign act_load_msg = recv_msg;
    assign act_load_len = recv_eff_len;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (recv_fire) begin
                    state_d = StSend;
                    k_d     = '0;
                end
            end
            StSend: begin
                if (send_fire) begin
                    if (!last_beat) begin
                        k_d = k_q + KW'(1);
                    end else if (act_load) begin
                        k_d = '0;
                    end else begin
                        state_d = StIdle;
                        k_d     = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                k_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    for (genvar j = 0; j < int'(N_LANES); j++) begin : g_lane
        logic [31:0] pos;
        assign pos          = 32'(k_q) * N_LANES + 32'(j);
        assign send_mask[j] = send_val && (pos < 32'(act_len));
        assign send_msg[j]  = send_mask[j] ? act_msg[pos[IDX_W-1:0]] : '0;
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer with BIT_WIDTH=16, N_SAMPLES=8, N_LANES=2.
module tb_lane_serializer;

    typedef struct {
        logic [15:0] m0;
        logic [15:0] m1;
        logic [1:0]  mask;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] recv_msg [8];
    logic [3:0]  recv_len;
    logic        recv_val = 1'b0;
    logic        recv_rdy;
    logic [15:0] send_msg [2];
    logic [1:0]  send_mask;
    logic        send_last;
    logic        send_val;
    logic        send_rdy = 1'b1;

    int    checks = 0;
    int    failures = 0;
    int    bubbles = 0;
    bit    mon_en = 1'b0;
    bit    bp_en = 1'b0;
    beat_t q[$];

    lane_serializer #(
        .BIT_WIDTH (16),
        .N_SAMPLES (8),
        .N_LANES   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv_msg  (recv_msg),
        .recv_len  (recv_len),
        .recv_val  (recv_val),
        .recv_rdy  (recv_rdy),
        .send_msg  (send_msg),
        .send_mask (send_mask),
        .send_last (send_last),
        .send_val  (send_val),
        .send_rdy  (send_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Backpressure pattern 1,0,0,1 repeating.
    initial begin
        logic [3:0] pat;
        int cyc;
        pat = 4'b1001;
        cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            send_rdy = bp_en ? pat[cyc % 4] : 1'b1;
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (send_val) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_unexpected: got beat 0x%0h expected none", send_msg[0]);
                end else begin
                    check("lane0", 32'(send_msg[0]), 32'(q[0].m0));
                    check("lane1", 32'(send_msg[1]), 32'(q[0].m1));
                    check("mask", 32'(send_mask), 32'(q[0].mask));
                    check("last", 32'(send_last), 32'(q[0].last));
                    if (send_rdy) begin
                        void'(q.pop_front());
                    end
                end
`ifndef LANE_SERIALIZER_PINGPONG_EN
                check("recv_rdy_busy", 32'(recv_rdy), 32'd0);
`endif
            end else begin
                check("recv_rdy_idle", 32'(recv_rdy), 32'd1);
                check("last_idle", 32'(send_last), 32'd0);
                check("mask_idle", 32'(send_mask), 32'd0);
                if (q.size() > 0) begin
                    bubbles++;
                end
            end
        end
    end

    task automatic offer(input logic [15:0] s [8], input int len);
        int eff;
        int nb;
        int n;
        logic rdy_seen;
        eff = (len == 0 || len > 8) ? 8 : len;
        nb  = (eff + 1) / 2;
        for (int k = 0; k < nb; k++) begin
            beat_t e;
            e.m0   = (2 * k < eff) ? s[2 * k] : 16'h0;
            e.m1   = (2 * k + 1 < eff) ? s[2 * k + 1] : 16'h0;
            e.mask = {(2 * k + 1 < eff), (2 * k < eff)};
            e.last = (k == nb - 1);
            q.push_back(e);
        end
        recv_msg = s;
        recv_len = 4'(len);
        recv_val = 1'b1;
        n = 0;
        forever begin
            rdy_seen = recv_rdy;
            @(posedge clk);
            #1;
            if (rdy_seen) break;
            n++;
            if (n > 100) begin
                checks++;
                failures++;
                $display("FAIL recv_timeout: got no recv_rdy expected handshake");
                break;
            end
        end
        recv_val = 1'b0;
        check("latency_val", 32'(send_val), 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || send_val) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_val"}, 32'(send_val), 32'd0);
        check({tag, "_rdy"}, 32'(recv_rdy), 32'd1);
        check({tag, "_last"}, 32'(send_last), 32'd0);
        check({tag, "_mask"}, 32'(send_mask), 32'd0);
        check({tag, "_msg0"}, 32'(send_msg[0]), 32'd0);
        check({tag, "_msg1"}, 32'(send_msg[1]), 32'd0);
    endtask

    initial begin
        logic [15:0] s [8];
        recv_len = '0;
        for (int i = 0; i < 8; i++) recv_msg[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) s[i] = 16'h10 + 16'(i);
        offer(s, 0);
        drain();

        for (int i = 0; i < 8; i++) s[i] = 16'(i + 1);
        offer(s, 5);
        drain();

        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) s[i] = 16'h20 + 16'(i);
        offer(s, 8);
        drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) s[i] = 16'h30 + 16'(i);
        offer(s, 9);
        drain();

        // Reset while the third of four beats is on the lanes.
        for (int i = 0; i < 8; i++) s[i] = 16'h40 + 16'(i);
        offer(s, 8);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        check_zero("midreset");
        reset = 1'b1;
        for (int i = 0; i < 8; i++) s[i] = 16'h50 + 16'(i);
        offer(s, 2);
        drain();

        for (int i = 0; i < 8; i++) s[i] = 16'hA0 + 16'(i);
        offer(s, 4);
        bubbles = 0;
        for (int i = 0; i < 8; i++) s[i] = 16'hB0 + 16'(i);
        offer(s, 4);
`ifdef LANE_SERIALIZER_PINGPONG_EN
        check("shadow_full_rdy", 32'(recv_rdy), 32'd0);
`endif
        drain();
`ifdef LANE_SERIALIZER_PINGPONG_EN
        check("bubbles", 32'(bubbles), 32'd0);
`else
        check("bubbles", 32'(bubbles), 32'd1);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected end of test");
        $fatal(1, "timeout");
    end

endmodule
